// File: rtl/adpll_mon_pkg.sv
// rtl/adpll_mon_pkg.sv - shared types and default parameters for the ADPLL lock monitor
package adpll_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } mon_state_t;

  localparam int DEF_TDC_W      = 12;
  localparam int DEF_DCO_W      = 16;
  localparam int SAMPLE_W       = DEF_DCO_W + DEF_TDC_W;
  localparam int DEF_DEPTH_LOG2 = 6;
  localparam int DEF_CNT_W      = 24;
  localparam int DEF_TIMEOUT    = 100000;

endpackage

// File: rtl/adpll_sample_fifo.sv
// rtl/adpll_sample_fifo.sv - synchronous register-array FIFO holding post-lock samples
module adpll_sample_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int SAMPLE_W   = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_valid,
  output logic                empty,
  output logic                full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [SAMPLE_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  wr_ok;
  logic                  rd_ok;

  assign empty = (count == '0);
  assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign wr_ok = wr_en & ~full & ~clr;
  assign rd_ok = rd_en & ~empty & ~clr;

  // Sample storage; contents are never reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (wr_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adpll_lock_monitor.sv
// rtl/adpll_lock_monitor.sv - ADPLL settling-time monitor with post-lock trace capture
module adpll_lock_monitor
  import adpll_mon_pkg::*;
#(
  parameter int TDC_W      = DEF_TDC_W,
  parameter int DCO_W      = DEF_DCO_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   channel_lock,
  input  logic [TDC_W-1:0]       tdc_word,
  input  logic [DCO_W-1:0]       dco_s_word,
  input  logic                   rd_en,
  output logic [DCO_W+TDC_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic [CNT_W-1:0]       settle_cnt,
  output logic                   settle_valid,
  output logic                   lock_fail,
  output logic                   lock_lost,
  output logic                   busy
);

  localparam int SMP_W = DCO_W + TDC_W;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0]      TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DEPTH_LOG2-1:0] WR_LAST = DEPTH_LOG2'(DEPTH - 1);

  mon_state_t            state;
  logic                  en_q;
  logic                  start;
  logic [CNT_W-1:0]      count;
  logic [DEPTH_LOG2-1:0] wr_cnt;
  logic                  clr;
  logic                  wr_en;
  logic                  full;

  assign start = en & ~en_q;
  assign clr   = (state == IDLE) & start;
  assign wr_en = (state == CAPTURE) & ~full;

  // Enable delay for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) en_q <= 1'b0;
    else     en_q <= en;
  end

  // Measurement FSM: settling counter, capture length and sticky result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      wr_cnt       <= '0;
      settle_cnt   <= '0;
      settle_valid <= 1'b0;
      lock_fail    <= 1'b0;
      lock_lost    <= 1'b0;
      busy         <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count        <= '0;
            wr_cnt       <= '0;
            settle_cnt   <= '0;
            settle_valid <= 1'b0;
            lock_fail    <= 1'b0;
            lock_lost    <= 1'b0;
            busy         <= 1'b1;
            state        <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (channel_lock) begin
            settle_cnt   <= count;
            settle_valid <= 1'b1;
            state        <= CAPTURE;
          end else if (count == TO_LAST) begin
            lock_fail <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        CAPTURE: begin
          if (!channel_lock) lock_lost <= 1'b1;
          wr_cnt <= wr_cnt + DEPTH_LOG2'(1);
          if (wr_cnt == WR_LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          state <= DONE;
        end
      endcase
    end
  end

  adpll_sample_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .SAMPLE_W   (SMP_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_data  ({dco_s_word, tdc_word}),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full)
  );

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// tb/tb_adpll_lock_monitor.sv - self-checking bench for adpll_lock_monitor
module tb_adpll_lock_monitor;

  localparam int TDC_W   = 12;
  localparam int DCO_W   = 16;
  localparam int CNT_W   = 24;
  localparam int TMO     = 1000;
  localparam int NSAMP   = 64;
  localparam int HMASK   = 16383;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             channel_lock;
  logic [TDC_W-1:0] tdc_word;
  logic [DCO_W-1:0] dco_s_word;
  logic             rd_en;
  logic [DCO_W+TDC_W-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic [CNT_W-1:0] settle_cnt;
  logic             settle_valid;
  logic             lock_fail;
  logic             lock_lost;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  logic [DCO_W+TDC_W-1:0] hist [HMASK+1];

  adpll_lock_monitor #(
    .TDC_W      (TDC_W),
    .DCO_W      (DCO_W),
    .DEPTH_LOG2 (6),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .channel_lock (channel_lock),
    .tdc_word     (tdc_word),
    .dco_s_word   (dco_s_word),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .settle_cnt   (settle_cnt),
    .settle_valid (settle_valid),
    .lock_fail    (lock_fail),
    .lock_lost    (lock_lost),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Rising-edge counter: edge k is the k-th posedge of the run
  always @(posedge clk) edge_n <= edge_n + 1;

  // Fresh random sample words each cycle, remembered by the edge that will sample them
  always @(negedge clk) begin
    tdc_word   = TDC_W'($urandom);
    dco_s_word = DCO_W'($urandom);
    hist[(edge_n + 1) & HMASK] = {dco_s_word, tdc_word};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  // Drop en for one sampled edge, then raise it; s is the edge that sees the start
  task automatic start_run(output int s);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    s = edge_n + 1;
  endtask

  // Drain NSAMP samples, expected to be the inputs seen at edges base..base+63
  task automatic read_all(input int base);
    logic [DCO_W+TDC_W-1:0] last;
    last = '0;
    for (int i = 0; i < NSAMP; i++) begin
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      chk("rd_valid", rd_valid, 1'b1);
      chk($sformatf("rd_data[%0d]", i), rd_data, hist[(base + i) & HMASK]);
      last = hist[(base + i) & HMASK];
      @(negedge clk);
    end
    chk("empty_after_drain", empty, 1'b1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("rd_valid_on_empty", rd_valid, 1'b0);
    chk("rd_data_held", rd_data, last);
  endtask

  // Lock becomes visible d edges after the first ACQUIRE edge: settle_cnt = d,
  // samples are taken at edges s+d+2 .. s+d+65 and busy drops after s+d+65
  task automatic lock_run(input int d, input bit conc, input bit drop, input bit do_read);
    int s;
    start_run(s);
    wait_to(s + d);
    channel_lock = 1'b1;
    wait_to(s + d + 1);
    chk("settle_valid", settle_valid, 1'b1);
    chk("settle_cnt", settle_cnt, 64'(d));
    chk("busy_capture", busy, 1'b1);
    chk("lock_fail_clear", lock_fail, 1'b0);
    if (drop) begin
      wait_to(s + d + 20);
      chk("lock_lost_before", lock_lost, 1'b0);
      channel_lock = 1'b0;
      wait_to(s + d + 23);
      channel_lock = 1'b1;
      chk("lock_lost_set", lock_lost, 1'b1);
    end
    if (conc) begin
      wait_to(s + d + 4);
      read_all(s + d + 2);
      chk("busy_after_conc", busy, 1'b0);
    end else begin
      wait_to(s + d + 64);
      chk("busy_last_capture", busy, 1'b1);
      wait_to(s + d + 65);
      chk("busy_done", busy, 1'b0);
      chk("not_empty_done", empty, 1'b0);
      if (drop) chk("lock_lost_sticky", lock_lost, 1'b1);
      if (do_read) read_all(s + d + 2);
    end
    channel_lock = 1'b0;
  endtask

  initial begin
    int s;
    int d;
    rst = 1'b1;
    en = 1'b0;
    channel_lock = 1'b0;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_settle_valid", settle_valid, 1'b0);
    chk("rst_settle_cnt", settle_cnt, 64'd0);
    chk("rst_lock_fail", lock_fail, 1'b0);
    chk("rst_lock_lost", lock_lost, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal lock 250 cycles in, readout after capture, then results held in IDLE
    lock_run(250, 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    @(negedge clk);
    chk("idle_keeps_valid", settle_valid, 1'b1);
    chk("idle_keeps_cnt", settle_cnt, 64'd250);
    chk("idle_busy", busy, 1'b0);

    // Immediate lock with concurrent readout
    channel_lock = 1'b1;
    lock_run(0, 1'b1, 1'b0, 1'b1);

    // Random lock delays, random choice of concurrent or post-capture readout
    for (int r = 0; r < 3; r++) begin
      d = int'($urandom_range(1, 400));
      lock_run(d, 1'($urandom), 1'b0, 1'b1);
    end

    // Lock dropped for three capture cycles
    lock_run(int'($urandom_range(1, 100)), 1'b0, 1'b1, 1'b1);

    // Timeout without lock
    channel_lock = 1'b0;
    start_run(s);
    wait_to(s + TMO - 1);
    chk("tmo_not_yet", lock_fail, 1'b0);
    chk("tmo_busy_before", busy, 1'b1);
    wait_to(s + TMO);
    chk("tmo_lock_fail", lock_fail, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_settle_valid", settle_valid, 1'b0);
    chk("tmo_empty", empty, 1'b1);

    // Lock on the final ACQUIRE cycle wins over timeout; data left unread
    lock_run(TMO - 1, 1'b0, 1'b0, 1'b0);

    // Abort in ACQUIRE; the start also flushes the unread buffer
    start_run(s);
    wait_to(s + 1);
    chk("flush_empty", empty, 1'b1);
    wait_to(s + 10);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_settle_valid", settle_valid, 1'b0);
    chk("abort_lock_fail", lock_fail, 1'b0);

    // Reset in the middle of capture
    start_run(s);
    wait_to(s + 5);
    channel_lock = 1'b1;
    wait_to(s + 40);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    en = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_settle_valid", settle_valid, 1'b0);
    chk("mid_rst_settle_cnt", settle_cnt, 64'd0);
    chk("mid_rst_lock_lost", lock_lost, 1'b0);
    chk("mid_rst_rd_valid", rd_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    channel_lock = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_empty", empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
